// File: rtl/adder_aligner.sv
// FP adder pre-alignment: picks the larger-exponent operand and shifts the smaller mantissa
// right one bit per cycle, keeping guard/round/sticky for the rounder.
module adder_aligner #(
  parameter int unsigned X         = 32,
  parameter int unsigned expo_bits = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [expo_bits-1:0]   exp_a,
  input  logic [X-expo_bits-1:0] mant_a,
  input  logic [expo_bits-1:0]   exp_b,
  input  logic [X-expo_bits-1:0] mant_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [expo_bits-1:0]   exp_out,
  output logic [X-expo_bits-1:0] mant_large,
  output logic [X-expo_bits-1:0] mant_small,
  output logic                   guard,
  output logic                   round_bit,
  output logic                   sticky,
  output logic                   swapped
);

  localparam int unsigned M    = X - expo_bits;
  localparam int unsigned CntW = $clog2(M + 3);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e state_q, state_d;

  logic [expo_bits-1:0] exp_q, exp_d;
  logic [M-1:0]         mant_large_q, mant_large_d;
  logic [M-1:0]         mant_small_q, mant_small_d;
  logic                 g_q, g_d, r_q, r_d, s_q, s_d;
  logic                 swapped_q, swapped_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 out_valid_q, out_valid_d;

  logic                 accept;
  logic                 a_large;
  logic [expo_bits-1:0] diff;
  logic [CntW-1:0]      cnt_init;

  assign accept  = in_valid && in_ready;
  assign a_large = (exp_a >= exp_b);
  assign diff    = a_large ? (exp_a - exp_b) : (exp_b - exp_a);

  // Past M+2 shifts every original bit is already folded into sticky.
  always_comb begin
    if (32'(diff) > (M + 2)) begin
      cnt_init = CntW'(M + 2);
    end else begin
      cnt_init = CntW'(diff);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = (cnt_init == '0) ? StDone : StShift;
        end
      end
      StShift: begin
        if (cnt_q == CntW'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_valid_q && out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready = (state_q == StIdle);
  end

  // Datapath next-state
  always_comb begin
    exp_d        = exp_q;
    mant_large_d = mant_large_q;
    mant_small_d = mant_small_q;
    g_d          = g_q;
    r_d          = r_q;
    s_d          = s_q;
    swapped_d    = swapped_q;
    cnt_d        = cnt_q;
    if (accept) begin
      exp_d        = a_large ? exp_a : exp_b;
      mant_large_d = a_large ? mant_a : mant_b;
      mant_small_d = a_large ? mant_b : mant_a;
      swapped_d    = !a_large;
      g_d          = 1'b0;
      r_d          = 1'b0;
      s_d          = 1'b0;
      cnt_d        = cnt_init;
    end else if (state_q == StShift) begin
      {mant_small_d, g_d, r_d} = {1'b0, mant_small_q, g_q};
      s_d                      = s_q | r_q;
      cnt_d                    = cnt_q - CntW'(1);
    end
  end

  // out_valid rises one cycle after entering DONE and drops with the handshake.
  assign out_valid_d = (state_q == StDone) && !(out_valid_q && out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q        <= '0;
      mant_large_q <= '0;
      mant_small_q <= '0;
      g_q          <= 1'b0;
      r_q          <= 1'b0;
      s_q          <= 1'b0;
      swapped_q    <= 1'b0;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      exp_q        <= exp_d;
      mant_large_q <= mant_large_d;
      mant_small_q <= mant_small_d;
      g_q          <= g_d;
      r_q          <= r_d;
      s_q          <= s_d;
      swapped_q    <= swapped_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign exp_out    = exp_q;
  assign mant_large = mant_large_q;
  assign mant_small = mant_small_q;
  assign guard      = g_q;
  assign round_bit  = r_q;
  assign sticky     = s_q;
  assign swapped    = swapped_q;

endmodule

// File: tb/tb_adder_aligner.sv
// Directed bench for adder_aligner: alignment results, latency, backpressure and reset abort.
module tb_adder_aligner;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  exp_a, exp_b;
  logic [23:0] mant_a, mant_b;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  exp_out;
  logic [23:0] mant_large, mant_small;
  logic        guard, round_bit, sticky, swapped;

  int tests_run = 0;
  int tests_failed = 0;

  // {exp_out, mant_large, mant_small, guard, round_bit, sticky, swapped}
  logic [59:0] res;
  assign res = {exp_out, mant_large, mant_small, guard, round_bit, sticky, swapped};

  adder_aligner #(
    .X        (32),
    .expo_bits(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .exp_a     (exp_a),
    .mant_a    (mant_a),
    .exp_b     (exp_b),
    .mant_b    (mant_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .exp_out   (exp_out),
    .mant_large(mant_large),
    .mant_small(mant_small),
    .guard     (guard),
    .round_bit (round_bit),
    .sticky    (sticky),
    .swapped   (swapped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents an operand pair, waits for the accept edge, then counts cycles to out_valid.
  // lat = 0 means out_valid never rose within the bound.
  task automatic run_op(input logic [7:0] ea, input logic [23:0] ma,
                        input logic [7:0] eb, input logic [23:0] mb, output int lat);
    exp_a = ea; mant_a = ma; exp_b = eb; mant_b = mb;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !in_ready; i++) step();
    step();
    in_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    exp_a = '0; exp_b = '0; mant_a = '0; mant_b = '0;
    #3;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_hs: got out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    tests_run++;
    if (res !== 60'h0) begin
      tests_failed++;
      $display("FAIL reset_data: got %h required 0", res);
    end
    step(); step();
    rst_n = 1'b1;
    step();
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL post_reset_idle: got out_valid=%b in_ready=%b required 0/1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_basic();
    int lat;
    out_ready = 1'b1;
    run_op(8'h80, 24'hC00000, 8'h7E, 24'h800001, lat);
    tests_run++;
    if (lat !== 3) begin
      tests_failed++;
      $display("FAIL basic_latency: got %0d required 3", lat);
    end
    tests_run++;
    if (res !== {8'h80, 24'hC00000, 24'h200000, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL basic_data: got %h required %h", res,
               {8'h80, 24'hC00000, 24'h200000, 1'b0, 1'b1, 1'b0, 1'b0});
    end
    step();
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_return_idle: got out_valid=%b in_ready=%b required 0/1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_swap();
    int lat;
    out_ready = 1'b1;
    run_op(8'h7F, 24'h800003, 8'h82, 24'h900000, lat);
    tests_run++;
    if (lat !== 4) begin
      tests_failed++;
      $display("FAIL swap_latency: got %0d required 4", lat);
    end
    tests_run++;
    if (res !== {8'h82, 24'h900000, 24'h100000, 1'b0, 1'b1, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL swap_data: got %h required %h", res,
               {8'h82, 24'h900000, 24'h100000, 1'b0, 1'b1, 1'b1, 1'b1});
    end
    step();
  endtask

  task automatic test_clamp();
    int lat;
    out_ready = 1'b1;
    run_op(8'hA0, 24'h800000, 8'h10, 24'h800000, lat);
    tests_run++;
    if (lat !== 27) begin
      tests_failed++;
      $display("FAIL clamp_latency: got %0d required 27", lat);
    end
    tests_run++;
    if (res !== {8'hA0, 24'h800000, 24'h000000, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL clamp_data: got %h required %h", res,
               {8'hA0, 24'h800000, 24'h000000, 1'b0, 1'b0, 1'b1, 1'b0});
    end
    step();
  endtask

  task automatic test_equal();
    int lat;
    out_ready = 1'b1;
    run_op(8'h90, 24'h800000, 8'h90, 24'hFFFFFF, lat);
    tests_run++;
    if (lat !== 1) begin
      tests_failed++;
      $display("FAIL equal_latency: got %0d required 1", lat);
    end
    tests_run++;
    if (res !== {8'h90, 24'h800000, 24'hFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL equal_data: got %h required %h", res,
               {8'h90, 24'h800000, 24'hFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0});
    end
    step();
  endtask

  task automatic test_back_to_back();
    int lat;
    int bad_hold;
    out_ready = 1'b0;
    exp_a = 8'h80; mant_a = 24'hC00000; exp_b = 8'h7E; mant_b = 24'h800001;
    in_valid = 1'b1;
    step();  // accept edge
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    tests_run++;
    if (lat !== 3) begin
      tests_failed++;
      $display("FAIL bp_latency: got %0d required 3", lat);
    end
    bad_hold = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          res !== {8'h80, 24'hC00000, 24'h200000, 1'b0, 1'b1, 1'b0, 1'b0}) begin
        bad_hold++;
      end
    end
    tests_run++;
    if (bad_hold !== 0) begin
      tests_failed++;
      $display("FAIL bp_hold: got %0d unstable cycles required 0", bad_hold);
    end
    // Release backpressure; in_valid stays high with the next operand pair.
    out_ready = 1'b1;
    exp_a = 8'h90; mant_a = 24'h800000; exp_b = 8'h90; mant_b = 24'hFFFFFF;
    step();
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_release: got out_valid=%b in_ready=%b required 0/1",
               out_valid, in_ready);
    end
    step();  // accept edge for the second operand
    in_valid = 1'b0;
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_second_accept: got in_ready=%b required 0", in_ready);
    end
    step();
    tests_run++;
    if (out_valid !== 1'b1 ||
        res !== {8'h90, 24'h800000, 24'hFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL bp_second_result: got valid=%b data=%h required 1/%h", out_valid, res,
               {8'h90, 24'h800000, 24'hFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0});
    end
    step();
  endtask

  task automatic test_reset_mid_shift();
    int seen;
    int lat;
    out_ready = 1'b1;
    exp_a = 8'hA0; mant_a = 24'h800000; exp_b = 8'h10; mant_b = 24'h800000;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || res !== 60'h0) begin
      tests_failed++;
      $display("FAIL midshift_reset: got valid=%b ready=%b data=%h required 0/1/0",
               out_valid, in_ready, res);
    end
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 35; i++) begin
      step();
      if (out_valid) seen++;
    end
    tests_run++;
    if (seen !== 0) begin
      tests_failed++;
      $display("FAIL midshift_stale: got %0d valid cycles required 0", seen);
    end
    run_op(8'h7F, 24'h800003, 8'h82, 24'h900000, lat);
    tests_run++;
    if (lat !== 4 || res !== {8'h82, 24'h900000, 24'h100000, 1'b0, 1'b1, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL midshift_recover: got lat=%0d data=%h required 4/%h", lat, res,
               {8'h82, 24'h900000, 24'h100000, 1'b0, 1'b1, 1'b1, 1'b1});
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_swap();
    test_clamp();
    test_equal();
    test_back_to_back();
    test_reset_mid_shift();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
